// File: rtl/stepper_pkg.sv
// stepper_pkg: shared types and helpers for the stepper-motor phase sequencer.
//   state_e      - sequencer FSM states (IDLE, RUN)
//   PHASE_TABLE  - 8-entry coil pattern table indexed by the 3-bit phase index
//   phase_step() - next phase index for a given direction and step mode
package stepper_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Even indices energise two coils, odd indices one coil; full-step
    // moves skip by two so they stay on whichever parity they started on.
    localparam logic [3:0] PHASE_TABLE [8] = '{
        4'b1001, 4'b1000, 4'b1010, 4'b0010,
        4'b0110, 4'b0100, 4'b0101, 4'b0001
    };

    // Next phase index: +/-1 in half-step, +/-2 in full-step, wrapping mod 8.
    function automatic logic [2:0] phase_step(input logic [2:0] idx,
                                              input logic       dir,
                                              input logic       half);
        logic [2:0] delta;
        delta = half ? 3'd1 : 3'd2;
        if (dir) begin
            return idx - delta;
        end else begin
            return idx + delta;
        end
    endfunction

endpackage

// File: rtl/stepper_tick_gen.sv
// stepper_tick_gen: step-rate counter for the stepper sequencer.
// Counts 0..PERIOD-1 while enabled and flags the terminal count.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr_i      - restart the count at 0 (wins over enable)
//   en_i       - advance the count
//   tick_o     - high for the one cycle the count sits at PERIOD-1 while enabled
module stepper_tick_gen #(
    parameter int unsigned PERIOD = 240000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned     CNT_W = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;

    // Period counter: clear on request, otherwise wrap at the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + ONE;
            end
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/stepper_drive.sv
// stepper_drive: command-driven 4-phase stepper-motor sequencer.
// Accepts move commands over valid/ready, steps the coil pattern every
// STEP_PERIOD clocks, tracks absolute position in half-steps.
//   cmd_valid/cmd_ready      - command handshake (ready only while idle)
//   cmd_dir/cmd_half/cmd_steps - direction, step mode, step count
//   abort                    - level, ends a running move without a done pulse
//   hold_en                  - keep the current phase energised while idle
//   motor_out                - registered coil drive
//   busy/done/aborted        - run status and one-cycle completion pulses
//   position                 - absolute position, two's complement, wraps
module stepper_drive
    import stepper_pkg::*;
#(
    parameter int unsigned STEP_PERIOD = 240000,
    parameter int unsigned STEPS_W     = 16,
    parameter int unsigned POS_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic               cmd_half,
    input  logic [STEPS_W-1:0] cmd_steps,
    input  logic               abort,
    input  logic               hold_en,
    output logic [3:0]         motor_out,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [POS_W-1:0]   position
);

    localparam logic [POS_W-1:0]   POS_ONE   = POS_W'(1);
    localparam logic [POS_W-1:0]   POS_TWO   = POS_W'(2);
    localparam logic [STEPS_W-1:0] STEPS_ONE = STEPS_W'(1);

    state_e             state_q;
    logic [2:0]         idx_q;
    logic [POS_W-1:0]   pos_q;
    logic [STEPS_W-1:0] rem_q;
    logic               dir_q;
    logic               half_q;
    logic [3:0]         motor_q;
    logic               busy_q;
    logic               done_q;
    logic               aborted_q;

    logic [2:0]         idx_d;
    logic [POS_W-1:0]   pos_d;
    logic [POS_W-1:0]   pos_delta_s;
    logic [3:0]         idle_pat_s;
    logic               accept_s;
    logic               run_s;
    logic               tick_s;

    assign run_s    = (state_q == ST_RUN);
    assign accept_s = cmd_valid && (state_q == ST_IDLE);

    stepper_tick_gen #(
        .PERIOD (STEP_PERIOD)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (accept_s),
        .en_i   (run_s),
        .tick_o (tick_s)
    );

    // Next index/position for the latched move, and the idle coil pattern.
    always_comb begin
        idx_d       = phase_step(idx_q, dir_q, half_q);
        pos_delta_s = half_q ? POS_ONE : POS_TWO;
        if (dir_q) begin
            pos_d = pos_q - pos_delta_s;
        end else begin
            pos_d = pos_q + pos_delta_s;
        end
        if (hold_en) begin
            idle_pat_s = PHASE_TABLE[idx_q];
        end else begin
            idle_pat_s = 4'b0000;
        end
    end

    // Sequencer FSM with its datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            pos_q     <= '0;
            rem_q     <= '0;
            dir_q     <= 1'b0;
            half_q    <= 1'b0;
            motor_q   <= 4'b0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    motor_q <= idle_pat_s;
                    if (cmd_valid) begin
                        dir_q  <= cmd_dir;
                        half_q <= cmd_half;
                        rem_q  <= cmd_steps;
                        if (cmd_steps == '0) begin
                            // Empty move: complete at once, no motion.
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                            motor_q <= PHASE_TABLE[idx_q];
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        // Abort beats a coincident terminal count: no step.
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                        motor_q   <= idle_pat_s;
                    end else if (tick_s) begin
                        idx_q   <= idx_d;
                        pos_q   <= pos_d;
                        rem_q   <= rem_q - STEPS_ONE;
                        motor_q <= PHASE_TABLE[idx_d];
                        if (rem_q == STEPS_ONE) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        motor_q <= PHASE_TABLE[idx_q];
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    motor_q <= 4'b0000;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign motor_out = motor_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign position  = pos_q;

endmodule
